// File: rtl/msb_serializer_if.sv
// Word-in / bit-out stream bundle for msb_serializer.
// master drives words in; slave is the serializer.
interface msb_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             sof;
    logic             eof;
    logic             word_done;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  bit_out,
        input  bit_valid,
        input  sof,
        input  eof,
        input  word_done,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output bit_out,
        output bit_valid,
        output sof,
        output eof,
        output word_done,
        output busy
    );
endinterface

// File: rtl/msb_serializer.sv
// MSB-first word serializer with framing flags
// and a programmable idle gap after each word.
module msb_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    msb_serializer_if.slave s
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GLAST =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             wd_q, wd_d;
    logic             xfer;

    assign xfer = s.din_valid && s.din_ready;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_d    = s.din;
                    cnt_d   = LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    wd_d  = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GLAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
        end
    end

    // Flags decode only from registered state; gated to 0 outside SHIFT.
    assign s.din_ready = (state_q == IDLE) && !reset;
    assign s.bit_valid = (state_q == SHIFT);
    assign s.bit_out   = s.bit_valid && sh_q[WIDTH-1];
    assign s.sof       = s.bit_valid && (cnt_q == LAST);
    assign s.eof       = s.bit_valid && (cnt_q == '0);
    assign s.word_done = wd_q;
    assign s.busy      = (state_q == SHIFT) || (state_q == GAP);
endmodule

// File: tb/tb_msb_serializer.sv
// Directed bench for msb_serializer across
// WIDTH=8/GAP=1, WIDTH=8/GAP=0 and WIDTH=1/GAP=1.
module tb_msb_serializer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    msb_serializer_if #(.WIDTH(8)) a8 ();
    msb_serializer_if #(.WIDTH(8)) a0 ();
    msb_serializer_if #(.WIDTH(1)) a1 ();

    msb_serializer #(.WIDTH(8), .GAP_CYCLES(1)) u8 (
        .clk(clk), .reset(reset), .s(a8)
    );
    msb_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .s(a0)
    );
    msb_serializer #(.WIDTH(1), .GAP_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .s(a1)
    );

    task automatic test_reset();
        logic [6:0] v;
        reset = 1'b1;
        a8.din = '0; a8.din_valid = 1'b0;
        a0.din = '0; a0.din_valid = 1'b0;
        a1.din = '0; a1.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        v = {a8.bit_out, a8.bit_valid, a8.sof, a8.eof,
             a8.word_done, a8.busy, a8.din_ready};
        checks++;
        if (v !== 7'b0) begin
            errors++;
            $display("FAIL reset_a8 got %b want 0000000", v);
        end
        v = {a0.bit_out, a0.bit_valid, a0.sof, a0.eof,
             a0.word_done, a0.busy, a0.din_ready};
        checks++;
        if (v !== 7'b0) begin
            errors++;
            $display("FAIL reset_a0 got %b want 0000000", v);
        end
        v = {a1.bit_out, a1.bit_valid, a1.sof, a1.eof,
             a1.word_done, a1.busy, a1.din_ready};
        checks++;
        if (v !== 7'b0) begin
            errors++;
            $display("FAIL reset_a1 got %b want 0000000", v);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a8.din_ready, a0.din_ready, a1.din_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready got %b want 111",
                     {a8.din_ready, a0.din_ready, a1.din_ready});
        end
    endtask

    task automatic test_a5();
        logic [7:0] w = 8'hA5;
        logic [3:0] v, e;
        @(negedge clk);
        a8.din = w; a8.din_valid = 1'b1;
        @(negedge clk);
        a8.din_valid = 1'b0; a8.din = '0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            v = {a8.bit_valid, a8.bit_out, a8.sof, a8.eof};
            e = {1'b1, w[8-i], 1'(i == 1), 1'(i == 8)};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL a5_bit%0d got %b want %b", i, v, e);
            end
        end
        @(negedge clk);
        v = {a8.bit_valid, a8.word_done, a8.busy, a8.din_ready};
        checks++;
        if (v !== 4'b0110) begin
            errors++;
            $display("FAIL a5_cyc9 got %b want 0110", v);
        end
        @(negedge clk);
        v = {a8.bit_valid, a8.word_done, a8.busy, a8.din_ready};
        checks++;
        if (v !== 4'b0001) begin
            errors++;
            $display("FAIL a5_cyc10 got %b want 0001", v);
        end
    endtask

    task automatic test_back_to_back();
        int sof_c[$];
        logic [7:0] s0 = '0;
        logic [7:0] s1 = '0;
        int wd = 0;
        @(negedge clk);
        a8.din = 8'h0F; a8.din_valid = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (a8.bit_valid && c <= 8) s0 = {s0[6:0], a8.bit_out};
            if (a8.bit_valid && c >= 11 && c <= 18)
                s1 = {s1[6:0], a8.bit_out};
            if (a8.sof) sof_c.push_back(c);
            if (a8.word_done) wd++;
            if (c == 1) a8.din = 8'hF0;
            if (c == 11) a8.din_valid = 1'b0;
        end
        checks++;
        if (sof_c.size() != 2) begin
            errors++;
            $display("FAIL b2b_sof_count got %0d want 2", sof_c.size());
        end else begin
            checks++;
            if (sof_c[0] != 1 || sof_c[1] - sof_c[0] != 10) begin
                errors++;
                $display("FAIL b2b_sof_cycles got %0d,%0d want 1,11",
                         sof_c[0], sof_c[1]);
            end
        end
        checks++;
        if (s0 !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_word0 got %h want 0f", s0);
        end
        checks++;
        if (s1 !== 8'hF0) begin
            errors++;
            $display("FAIL b2b_word1 got %h want f0", s1);
        end
        checks++;
        if (wd != 2) begin
            errors++;
            $display("FAIL b2b_word_done got %0d want 2", wd);
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        @(negedge clk);
        a8.din = 8'hFF; a8.din_valid = 1'b1;
        @(negedge clk);
        a8.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a8.bit_valid, a8.bit_out, a8.sof, a8.eof} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_bit4 got %b want 1100",
                     {a8.bit_valid, a8.bit_out, a8.sof, a8.eof});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a8.bit_valid, a8.busy, a8.word_done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_after_reset got %b want 000",
                     {a8.bit_valid, a8.busy, a8.word_done});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (a8.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready got %b want 1", a8.din_ready);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a8.bit_valid !== 1'b0 || a8.word_done !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_stray got %0d want 0", stray);
        end
    endtask

    task automatic test_reset_priority();
        int stray = 0;
        @(negedge clk);
        reset = 1'b1;
        a8.din = 8'h55; a8.din_valid = 1'b1;
        #1;
        checks++;
        if (a8.din_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready got %b want 0", a8.din_ready);
        end
        @(negedge clk);
        a8.din_valid = 1'b0;
        reset = 1'b0;
        checks++;
        if ({a8.bit_valid, a8.busy} !== 2'b00) begin
            errors++;
            $display("FAIL prio_state got %b want 00",
                     {a8.bit_valid, a8.busy});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a8.bit_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL prio_stray got %0d want 0", stray);
        end
    endtask

    task automatic test_gap0();
        logic [7:0] w = 8'h81;
        logic [3:0] v, e;
        @(negedge clk);
        a0.din = w; a0.din_valid = 1'b1;
        @(negedge clk);
        a0.din_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            v = {a0.bit_valid, a0.bit_out, a0.sof, a0.eof};
            e = {1'b1, w[8-i], 1'(i == 1), 1'(i == 8)};
            checks++;
            if (v !== e) begin
                errors++;
                $display("FAIL gap0_bit%0d got %b want %b", i, v, e);
            end
        end
        @(negedge clk);
        v = {a0.bit_valid, a0.word_done, a0.busy, a0.din_ready};
        checks++;
        if (v !== 4'b0101) begin
            errors++;
            $display("FAIL gap0_cyc9 got %b want 0101", v);
        end
        a0.din = 8'h3C; a0.din_valid = 1'b1;
        @(negedge clk);
        a0.din_valid = 1'b0;
        v = {a0.bit_valid, a0.sof, a0.bit_out, a0.word_done};
        checks++;
        if (v !== 4'b1100) begin
            errors++;
            $display("FAIL gap0_cyc10 got %b want 1100", v);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_width1();
        logic [3:0] v;
        @(negedge clk);
        a1.din = 1'b1; a1.din_valid = 1'b1;
        @(negedge clk);
        a1.din_valid = 1'b0; a1.din = 1'b0;
        v = {a1.bit_valid, a1.sof, a1.eof, a1.bit_out};
        checks++;
        if (v !== 4'b1111) begin
            errors++;
            $display("FAIL w1_bit got %b want 1111", v);
        end
        @(negedge clk);
        v = {a1.bit_valid, a1.word_done, a1.busy, a1.din_ready};
        checks++;
        if (v !== 4'b0110) begin
            errors++;
            $display("FAIL w1_gap got %b want 0110", v);
        end
        @(negedge clk);
        v = {a1.bit_valid, a1.word_done, a1.busy, a1.din_ready};
        checks++;
        if (v !== 4'b0001) begin
            errors++;
            $display("FAIL w1_idle got %b want 0001", v);
        end
        a1.din = 1'b0; a1.din_valid = 1'b1;
        @(negedge clk);
        a1.din_valid = 1'b0;
        v = {a1.bit_valid, a1.sof, a1.eof, a1.bit_out};
        checks++;
        if (v !== 4'b1110) begin
            errors++;
            $display("FAIL w1_zero got %b want 1110", v);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_din_toggle();
        logic [7:0] w = 8'hC3;
        logic [1:0] v;
        logic [2:0] t;
        @(negedge clk);
        a8.din = w; a8.din_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            v = {a8.bit_valid, a8.bit_out};
            checks++;
            if (v !== {1'b1, w[8-i]}) begin
                errors++;
                $display("FAIL toggle_bit%0d got %b want %b",
                         i, v, {1'b1, w[8-i]});
            end
            a8.din = 8'($urandom);
            a8.din_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        a8.din_valid = 1'b0;
        checks++;
        if ({a8.bit_valid, a8.word_done} !== 2'b01) begin
            errors++;
            $display("FAIL toggle_done got %b want 01",
                     {a8.bit_valid, a8.word_done});
        end
        @(negedge clk);
        t = {a8.bit_valid, a8.busy, a8.din_ready};
        checks++;
        if (t !== 3'b001) begin
            errors++;
            $display("FAIL toggle_idle got %b want 001", t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_reset_mid();
        test_reset_priority();
        test_gap0();
        test_width1();
        test_din_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/msb_serializer.md
MSB_SERIALIZER -- requirements
Module: msb_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of bits per word, legal range 1..32.
REQ-002 SHALL provide parameter GAP_CYCLES, default 1: idle cycles inserted after each word, legal range 0..15.
REQ-003 SHALL provide port clk  input  1: clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset  input  1: reset, synchronous, active-high; clock clk.
REQ-005 SHALL provide port din  input  WIDTH: parallel word to serialize.
REQ-006 SHALL provide port din_valid  input  1: din holds a word to transfer.
REQ-007 SHALL provide port din_ready  output  1: block can accept a word this cycle.
REQ-008 SHALL provide port bit_out  output  1: serial data, MSB first.
REQ-009 SHALL provide port bit_valid  output  1: bit_out carries a data bit this cycle.
REQ-010 SHALL provide port sof  output  1: current bit is the first bit of a word; downstream divisibility FSM clears its remainder on it.
REQ-011 SHALL provide port eof  output  1: current bit is the last bit of a word.
REQ-012 SHALL provide port word_done  output  1: one-cycle pulse in the cycle after eof.
REQ-013 SHALL provide port busy  output  1: high in SHIFT or GAP.

Function
REQ-014 SHALL implement three states: IDLE, SHIFT, GAP.
REQ-015 SHALL complete a transfer on a rising edge with din_valid=1 and din_ready=1; no other edge loads din.
REQ-016 SHALL drive din_ready = (state==IDLE) AND NOT reset.
REQ-017 On transfer SHALL load din into a WIDTH-bit shift register, set bit counter to WIDTH-1, and enter SHIFT.
REQ-018 In SHIFT SHALL drive bit_valid=1 and bit_out=shift register MSB; each edge shifts left by one and decrements the counter.
REQ-019 SHALL emit the first bit in the cycle immediately after the transfer edge (latency 1), and WIDTH bits in WIDTH consecutive cycles.
REQ-020 SHALL assert sof when the counter equals WIDTH-1 and eof when it equals 0; with WIDTH=1 both assert in the same cycle.
REQ-021 When the counter is 0 in SHIFT, the next state SHALL be GAP if GAP_CYCLES>0, else IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with bit_valid=0, then go to IDLE.
REQ-023 SHALL pulse word_done for exactly one cycle, in the cycle after eof (first GAP cycle, or the IDLE cycle when GAP_CYCLES=0).
REQ-024 Word throughput SHALL be one word per WIDTH+GAP_CYCLES+1 cycles with din_valid held high.
REQ-025 Changes on din or din_valid outside a transfer edge SHALL NOT affect bit_out, the counter, or the state.
REQ-026 When bit_valid=0, bit_out, sof and eof SHALL be 0.
REQ-027 All outputs except din_ready SHALL be registered or decoded only from registered state (no combinational path from din/din_valid).
REQ-028 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-029 An edge with reset=1 SHALL force IDLE, clear the shift register and counters, and suppress word_done.
REQ-030 After reset: bit_out=0, bit_valid=0, sof=0, eof=0, word_done=0, busy=0; din_ready=1 once reset is low.
REQ-031 Reset asserted mid-word SHALL abort the word; no further bits of it and no word_done SHALL appear.
REQ-032 Reset SHALL take priority over a simultaneous transfer; that word SHALL be dropped.

Verification
REQ-033 WIDTH=8, GAP=1, din=8'hA5 transferred at edge 0 -> bit_out 1,0,1,0,0,1,0,1 in cycles 1-8; sof cycle 1; eof cycle 8; word_done cycle 9; din_ready=1 cycle 10.
REQ-034 din_valid held high, din=8'h0F then 8'hF0 -> sof pulses exactly 10 cycles apart; bit streams 00001111 then 11110000; word_done twice.
REQ-035 Reset asserted during 4th bit of 8'hFF -> next cycle bit_valid=0, busy=0, din_ready=1 after reset release; no word_done.
REQ-036 GAP_CYCLES=0, din=8'h81 -> eof cycle 8; word_done and din_ready=1 in cycle 9; next sof earliest cycle 10.
REQ-037 WIDTH=1, din=1 -> one cycle with bit_valid=sof=eof=bit_out=1.
REQ-038 din toggled randomly during SHIFT -> serialized bits match the value captured at the transfer edge.
